gcd_engine: RTL
===============

# gcd_engine

Parametrised GCD unit with its datapath and controller in one block. It accepts an operand pair over a valid/ready handshake and computes the GCD in either subtractive (Euclid) or binary (Stein) mode, one algorithm step per clock. It returns the result, the step count and a zero-operand flag over a second valid/ready handshake. It is the successor to the fixed-width go/done GCD controller and is the unit the rest of the design instantiates wherever a GCD is needed.

## Interface
- WIDTH, 16: operand and result width in bits (≥2).
- CNT_W, 16: width of the cycles counter (≥1).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a_in  in  WIDTH  operand A, unsigned.
- b_in  in  WIDTH  operand B, unsigned.
- mode  in  1  0 = subtractive, 1 = binary (Stein); sampled at accept.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  gcd(A,B); gcd(0,x) = x; gcd(0,0) = 0.
- cycles  out  CNT_W  number of CALC cycles used; saturates at 2^CNT_W−1.
- zero_err  out  1  both operands were 0; valid with out_valid.
- busy  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE. There are no other states; any illegal encoding goes to IDLE.
- Internal registers: a, b (WIDTH), k (shift count, clog2(WIDTH) bits), md (latched mode), cnt (CNT_W).
- IDLE: in_ready=1. On in_valid & in_ready: a←a_in, b←b_in, md←mode, k←0, cnt←0, then go to CALC.
- CALC, every cycle: cnt←cnt+1 (saturating), then exactly one of the following, in priority order:
  - a==0 or b==0 or a==b: result←(a==0 ? b : a) << k; zero_err←(a==0 & b==0); cycles←cnt+1 (saturating); go to DONE.
  - md=0: if a>b then a←a−b, else b←b−a.
  - md=1, a and b both even: a←a>>1, b←b>>1, k←k+1.
  - md=1, only a even: a←a>>1. Only b even: b←b>>1.
  - md=1, both odd: if a>b then a←(a−b)>>1, else b←(b−a)>>1.
- DONE: out_valid=1. result, cycles and zero_err are stable. On out_ready, go to IDLE and deassert out_valid.
- Arithmetic:
  - All values are unsigned.
  - Subtraction is performed only as larger minus smaller, so it never wraps.
  - In binary mode k ≤ WIDTH−1 and result << k fits in WIDTH bits by construction; the result is truncated to WIDTH bits.
- Operands presented while not in IDLE are ignored, since in_ready=0.
- result, cycles and zero_err keep their last values after DONE until the next termination.

## Timing
- Reset values: state IDLE; in_ready=1; out_valid=0; busy=0; result=0; cycles=0; zero_err=0; a, b, k, cnt=0.
- rst has priority over all other inputs. If asserted mid-CALC or mid-DONE, the operation is aborted, no out_valid is produced, and the block is in IDLE on the next cycle.
- Accept happens on edge T. CALC occupies cycles T+1 … T+N, where N is the value reported on cycles. out_valid rises after edge T+N+1 at the earliest... specifically, out_valid is high from the cycle following the last CALC cycle.
- Minimum latency, accept to out_valid: 2 cycles (N=1, e.g. equal or zero operands).
- A back-to-back handshake is allowed: with out_ready held high, DONE lasts 1 cycle, IDLE lasts 1 cycle, and a new accept is possible in that IDLE cycle.
- in_ready and busy are combinational from the state register only; there is no input-to-output combinational path.
- Subtractive worst case is 2^WIDTH−1 CALC cycles. Binary worst case is ≤ 2·WIDTH CALC cycles.

## Test plan
- Reset mid-op: start (255,1) in mode 0, assert rst on the 10th CALC cycle → the next cycle has in_ready=1, out_valid=0, result=0, cycles=0; no out_valid appears afterwards.
- Subtractive: (12,8) mode 0 → result=4, cycles=3, zero_err=0, out_valid 4 cycles after the accept edge. Binary: (12,8) mode 1 → result=4, cycles=5.
- Zero handling: (0,0) → result=0, zero_err=1, cycles=1. (0,5) → 5, zero_err=0. (9,9) → 9, cycles=1, in both modes.
- Backpressure: out_ready held low for 20 cycles → out_valid, result and cycles stay stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready → IDLE the next cycle.
- Saturation, WIDTH=8, CNT_W=4: (255,1) mode 0 → result=1, cycles=15. Same pair in mode 1 → result=1, cycles ≤ 16.
- Randomised: 1000 random pairs across both modes, with random out_ready stalls and back-to-back accepts → result matches a reference GCD model; binary-mode cycles ≤ 2·WIDTH.

Source files
------------

// File: rtl/gcd_engine.sv
// gcd_engine: GCD unit with valid/ready in/out handshakes.
// Subtractive (Euclid) or binary (Stein) mode, one step per clock.
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] cycles,
  output logic             zero_err,
  output logic             busy
);

  localparam int KW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             md_q, md_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             zerr_q, zerr_d;

  logic             term;
  logic             a_gt;
  logic [WIDTH-1:0] dab;
  logic [WIDTH-1:0] dba;
  logic [CNT_W-1:0] cnt_inc;

  assign term    = (a_q == '0) || (b_q == '0) || (a_q == b_q);
  assign a_gt    = a_q > b_q;
  assign dab     = a_q - b_q;
  assign dba     = b_q - a_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = in_valid ? CALC : IDLE;
      CALC:    state_d = term ? DONE : CALC;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs, decoded from state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == DONE);
  end

  // Datapath next-state: load on accept, one algorithm step per CALC cycle
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    k_d    = k_q;
    md_d   = md_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    cyc_d  = cyc_q;
    zerr_d = zerr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a_in;
          b_d   = b_in;
          md_d  = mode;
          k_d   = '0;
          cnt_d = '0;
        end
      end
      CALC: begin
        cnt_d = cnt_inc;
        if (term) begin
          res_d  = ((a_q == '0) ? b_q : a_q) << k_q;
          zerr_d = (a_q == '0) && (b_q == '0);
          cyc_d  = cnt_inc;
        end else if (!md_q) begin
          if (a_gt) a_d = dab;
          else      b_d = dba;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_gt) begin
          a_d = dab >> 1;
        end else begin
          b_d = dba >> 1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      k_q    <= '0;
      md_q   <= 1'b0;
      cnt_q  <= '0;
      res_q  <= '0;
      cyc_q  <= '0;
      zerr_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      k_q    <= k_d;
      md_q   <= md_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      cyc_q  <= cyc_d;
      zerr_q <= zerr_d;
    end
  end

  assign result   = res_q;
  assign cycles   = cyc_q;
  assign zero_err = zerr_q;

endmodule
